// File: rtl/systolic_semiring_array_pkg.sv
// systolic_pkg: semiring mode encodings, FSM states and accumulator identity helper
package systolic_pkg;
  localparam logic [1:0] MODE_WRAP = 2'd0;
  localparam logic [1:0] MODE_SAT  = 2'd1;
  localparam logic [1:0] MODE_MAXP = 2'd2;
  localparam logic [1:0] MODE_MINP = 2'd3;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_READ} state_t;
  // fill bit of the identity: all-ones for min-plus, zero otherwise
  function automatic logic ident(input logic [1:0] mode);
    return mode == MODE_MINP;
  endfunction
endpackage

// File: rtl/systolic_semiring_array_if.sv
// systolic_semiring_array_if: command, operand stream and result stream signals
interface systolic_semiring_array_if #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int ACC_W = 16,
  parameter int KW    = 8
);
  logic             start;
  logic [1:0]       mode;
  logic [KW-1:0]    k_len;
  logic             in_valid;
  logic             in_ready;
  logic [N*W-1:0]   a_vec;
  logic [N*W-1:0]   b_vec;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             busy;
  logic             done;
  modport master (
    output start, mode, k_len, in_valid, a_vec, b_vec, out_ready,
    input  in_ready, out_valid, out_data, busy, done
  );
  modport slave (
    input  start, mode, k_len, in_valid, a_vec, b_vec, out_ready,
    output in_ready, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/systolic_semiring_array_mac_cell.sv
// systolic_mac_cell: one output-stationary PE; forwards a east and b south, folds a,b into acc
module systolic_mac_cell
  import systolic_pkg::*;
#(
  parameter int W     = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic [1:0]       i_mode,
  input  logic [W-1:0]     i_a,
  input  logic             i_a_v,
  input  logic [W-1:0]     i_b,
  input  logic             i_b_v,
  output logic [W-1:0]     o_a,
  output logic             o_a_v,
  output logic [W-1:0]     o_b,
  output logic             o_b_v,
  output logic [ACC_W-1:0] o_acc
);
  logic [W-1:0]     r_a, r_b;
  logic             r_a_v, r_b_v;
  logic [ACC_W-1:0] r_acc, w_nxt, w_ab;
  logic [2*W-1:0]   w_prod;
  logic [ACC_W:0]   w_sum;
  assign w_prod = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};
  assign w_sum  = {1'b0, r_acc} + (ACC_W+1)'(w_prod);
  assign w_ab   = ACC_W'({1'b0, i_a} + {1'b0, i_b});
  assign w_nxt  = i_mode == MODE_WRAP ? w_sum[ACC_W-1:0] :
                  i_mode == MODE_SAT  ? (w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0]) :
                  i_mode == MODE_MAXP ? (w_ab > r_acc ? w_ab : r_acc) :
                                        (w_ab < r_acc ? w_ab : r_acc);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_a_v <= 1'b0;
      r_b_v <= 1'b0;
      r_acc <= '0;
    end else begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_a_v <= i_a_v;
      r_b_v <= i_b_v;
      if (i_clr) r_acc <= {ACC_W{ident(i_mode)}};
      else if (i_a_v && i_b_v) r_acc <= w_nxt;
    end
  end
  assign o_a   = r_a;
  assign o_b   = r_b;
  assign o_a_v = r_a_v;
  assign o_b_v = r_b_v;
  assign o_acc = r_acc;
endmodule

// File: rtl/systolic_semiring_array.sv
// systolic_semiring_array: N x N output-stationary semiring matrix multiply with skewed
// operand injection and element-serial, row-major readout
module systolic_semiring_array
  import systolic_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int ACC_W = 16,
  parameter int KW    = 8
) (
  input logic clk,
  input logic rst_n,
  systolic_semiring_array_if.slave bus
);
  localparam int IW = N > 1 ? $clog2(N*N) : 1;
  localparam int DW = $clog2(2*N);
  if (ACC_W < 2*W) begin : g_bad_width
    $error("ACC_W must be at least 2*W");
  end
  state_t           r_st, w_nxt;
  logic [1:0]       r_mode, w_mode;
  logic [KW-1:0]    r_klen, r_kcnt;
  logic [DW-1:0]    r_dcnt;
  logic [IW-1:0]    r_idx;
  logic             r_done;
  logic             w_start, w_in_xfer, w_out_xfer, w_last_k, w_last_d, w_last_r;
  logic [W-1:0]     w_ah  [N][N+1];
  logic             w_ahv [N][N+1];
  logic [W-1:0]     w_bv  [N+1][N];
  logic             w_bvv [N+1][N];
  logic [ACC_W-1:0] w_acc [N*N];
  assign w_start    = bus.start && r_st == S_IDLE;
  assign w_in_xfer  = bus.in_valid && r_st == S_LOAD;
  assign w_out_xfer = bus.out_ready && r_st == S_READ;
  assign w_last_k   = (r_kcnt + 1'b1) == r_klen;
  assign w_last_d   = r_dcnt == DW'(2*N-2);
  assign w_last_r   = r_idx == IW'(N*N-1);
  assign w_mode     = w_start ? bus.mode : r_mode;
  always_comb begin
    w_nxt = r_st;
    case (r_st)
      S_IDLE:  w_nxt = w_start ? (bus.k_len == '0 ? S_READ : S_LOAD) : S_IDLE;
      S_LOAD:  w_nxt = w_in_xfer && w_last_k ? S_DRAIN : S_LOAD;
      S_DRAIN: w_nxt = w_last_d ? S_READ : S_DRAIN;
      S_READ:  w_nxt = w_out_xfer && w_last_r ? S_IDLE : S_READ;
      default: w_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st   <= S_IDLE;
      r_mode <= '0;
      r_klen <= '0;
      r_kcnt <= '0;
      r_dcnt <= '0;
      r_idx  <= '0;
      r_done <= 1'b0;
    end else begin
      r_st   <= w_nxt;
      r_done <= w_out_xfer && w_last_r;
      if (w_start) begin
        r_mode <= bus.mode;
        r_klen <= bus.k_len;
        r_kcnt <= '0;
        r_dcnt <= '0;
        r_idx  <= '0;
      end
      if (w_in_xfer) r_kcnt <= r_kcnt + 1'b1;
      if (r_st == S_DRAIN) r_dcnt <= r_dcnt + 1'b1;
      if (w_out_xfer) r_idx <= r_idx + 1'b1;
    end
  end
  // lane i gets i+1 stages so pair k hits cell(i,j) exactly i+j+1 cycles after acceptance
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [W-1:0] r_sa [i+1];
    logic [W-1:0] r_sb [i+1];
    logic [i:0]   r_sav, r_sbv;
    logic         w_unused_edge;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sav <= '0;
        r_sbv <= '0;
        for (int d = 0; d <= i; d++) begin
          r_sa[d] <= '0;
          r_sb[d] <= '0;
        end
      end else begin
        r_sa[0]  <= bus.a_vec[i*W +: W];
        r_sb[0]  <= bus.b_vec[i*W +: W];
        r_sav[0] <= w_in_xfer;
        r_sbv[0] <= w_in_xfer;
        for (int d = 1; d <= i; d++) begin
          r_sa[d]  <= r_sa[d-1];
          r_sb[d]  <= r_sb[d-1];
          r_sav[d] <= r_sav[d-1];
          r_sbv[d] <= r_sbv[d-1];
        end
      end
    end
    assign w_ah[i][0]  = r_sa[i];
    assign w_ahv[i][0] = r_sav[i];
    assign w_bv[0][i]  = r_sb[i];
    assign w_bvv[0][i] = r_sbv[i];
    assign w_unused_edge = ^{w_ah[i][N], w_ahv[i][N], w_bv[N][i], w_bvv[N][i]};
  end
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_mac_cell #(.W(W), .ACC_W(ACC_W)) u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_start),
        .i_mode(w_mode),
        .i_a   (w_ah[i][j]),
        .i_a_v (w_ahv[i][j]),
        .i_b   (w_bv[i][j]),
        .i_b_v (w_bvv[i][j]),
        .o_a   (w_ah[i][j+1]),
        .o_a_v (w_ahv[i][j+1]),
        .o_b   (w_bv[i+1][j]),
        .o_b_v (w_bvv[i+1][j]),
        .o_acc (w_acc[i*N+j])
      );
    end
  end
  assign bus.in_ready  = r_st == S_LOAD;
  assign bus.out_valid = r_st == S_READ;
  assign bus.out_data  = r_st == S_READ ? w_acc[r_idx] : '0;
  assign bus.busy      = r_st != S_IDLE;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_systolic_semiring_array.sv
// tb_systolic_semiring_array: directed vectors with hand-computed results for the 4x4 array
module tb_systolic_semiring_array;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  logic [15:0] ex [16];
  systolic_semiring_array_if #(.N(4), .W(8), .ACC_W(16), .KW(8)) bus ();
  systolic_semiring_array #(.N(4), .W(8), .ACC_W(16), .KW(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input logic [1:0] mode, input logic [7:0] k);
    bus.start = 1'b1;
    bus.mode  = mode;
    bus.k_len = k;
    step();
    bus.start = 1'b0;
  endtask
  task automatic feed(input logic [31:0] a0, input logic [31:0] b0,
                      input logic [31:0] a1, input logic [31:0] b1, input bit gap);
    for (int k = 0; k < 2; k++) begin
      bus.a_vec    = k == 0 ? a0 : a1;
      bus.b_vec    = k == 0 ? b0 : b1;
      bus.in_valid = 1'b1;
      chk("in_ready", {31'd0, bus.in_ready}, 32'd1);
      step();
      bus.in_valid = 1'b0;
      if (gap) step();
    end
  endtask
  task automatic readout(input logic [15:0] exv [16], input int stall);
    int n = 0;
    while (!bus.out_valid && n < 40) begin
      step();
      n++;
    end
    chk("out_valid_timeout", {31'd0, bus.out_valid}, 32'd1);
    for (int e = 0; e < 16; e++) begin
      if (e == stall) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          step();
          chk("stall_data", {16'd0, bus.out_data}, {16'd0, exv[e]});
          chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
        end
      end
      bus.out_ready = 1'b1;
      chk($sformatf("elem%0d", e), {16'd0, bus.out_data}, {16'd0, exv[e]});
      step();
    end
    bus.out_ready = 1'b0;
    chk("done_pulse", {31'd0, bus.done}, 32'd1);
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);
    step();
    chk("done_low", {31'd0, bus.done}, 32'd0);
  endtask
  task automatic fill(input logic [15:0] v);
    for (int e = 0; e < 16; e++) ex[e] = v;
  endtask
  task automatic fill_t1();
    for (int e = 0; e < 16; e++) ex[e] = e < 4 ? 16'd11 : e < 8 ? 16'd14 : e < 12 ? 16'd17 : 16'd20;
  endtask
  task automatic run2(input logic [1:0] mode, input logic [31:0] a0, input logic [31:0] b0,
                      input logic [31:0] a1, input logic [31:0] b1, input bit gap, input int stall);
    do_start(mode, 8'd2);
    feed(a0, b0, a1, b1, gap);
    readout(ex, stall);
  endtask
  initial begin
    bus.start = 1'b0; bus.mode = 2'd0; bus.k_len = 8'd0; bus.in_valid = 1'b0;
    bus.a_vec = '0; bus.b_vec = '0; bus.out_ready = 1'b0;
    step();
    step();
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, bus.out_data}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    rst_n = 1'b1;
    step();
    fill_t1();
    run2(2'b00, 32'h04030201, 32'h01010101, 32'h08070605, 32'h02020202, 1'b0, -1);
    fill(16'd64514);
    run2(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1);
    fill(16'd65535);
    run2(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1);
    fill(16'd300);
    run2(2'b10, 32'h03030303, 32'h0A0A0A0A, 32'hC8C8C8C8, 32'h64646464, 1'b0, -1);
    fill(16'd13);
    run2(2'b11, 32'h03030303, 32'h0A0A0A0A, 32'hC8C8C8C8, 32'h64646464, 1'b0, -1);
    fill_t1();
    run2(2'b00, 32'h04030201, 32'h01010101, 32'h08070605, 32'h02020202, 1'b1, 6);
    do_start(2'b00, 8'd2);
    bus.a_vec = 32'h04030201; bus.b_vec = 32'h01010101; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort_out_data", {16'd0, bus.out_data}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    rst_n = 1'b1;
    step();
    fill_t1();
    run2(2'b00, 32'h04030201, 32'h01010101, 32'h08070605, 32'h02020202, 1'b0, -1);
    fill(16'd0);
    do_start(2'b00, 8'd0);
    readout(ex, -1);
    fill(16'hFFFF);
    do_start(2'b11, 8'd0);
    bus.start = 1'b1; bus.mode = 2'b00; bus.k_len = 8'd2;
    step();
    bus.start = 1'b0;
    chk("ign_busy", {31'd0, bus.busy}, 32'd1);
    chk("ign_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("ign_out_valid", {31'd0, bus.out_valid}, 32'd1);
    readout(ex, -1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
